// File: rtl/btn_press_classifier.sv
// Push-button front end: synchronize, debounce, then classify each gesture
// as a short, long or double press with single-cycle result pulses.
module btn_press_classifier #(
  parameter int DB_CYCLES   = 1000000,
  parameter int LONG_CYCLES = 80000000,
  parameter int DBL_CYCLES  = 30000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic pressed_o,
  output logic short_o,
  output logic long_o,
  output logic double_o
);

  localparam int MAXP = (LONG_CYCLES > DBL_CYCLES) ? LONG_CYCLES : DBL_CYCLES;
  localparam int TW   = $clog2(MAXP) + 1;
  localparam int DW   = $clog2(DB_CYCLES) + 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
  // Expiry fires on the edge where the timer would reach LIMIT-1, so the pulse
  // lands exactly LIMIT cycles after the debounced edge that started the phase.
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 2);
  localparam logic [TW-1:0] DBL_LAST  = TW'(DBL_CYCLES - 2);

  typedef enum logic [2:0] {IDLE, PRESS1, LONG_HELD, WAIT2, PRESS2} state_t;

  logic [1:0]    sync_q;
  logic [DW-1:0] db_cnt;
  logic          pressed_d;
  logic          rise, fall;
  state_t        state;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], btn_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt    <= '0;
      pressed_o <= 1'b0;
      pressed_d <= 1'b0;
    end else begin
      pressed_d <= pressed_o;
      if (sync_q[1] == pressed_o) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        pressed_o <= sync_q[1];
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  assign rise      = pressed_o & ~pressed_d;
  assign fall      = ~pressed_o & pressed_d;
  assign timer_inc = (&timer) ? timer : timer + TW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      short_o  <= 1'b0;
      long_o   <= 1'b0;
      double_o <= 1'b0;
    end else begin
      short_o  <= 1'b0;
      long_o   <= 1'b0;
      double_o <= 1'b0;
      timer    <= timer_inc;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESS1;
            timer <= '0;
          end
        end
        PRESS1: begin
          if (fall) begin
            state <= WAIT2;
            timer <= '0;
          end else if (timer == LONG_LAST) begin
            long_o <= 1'b1;
            state  <= LONG_HELD;
            timer  <= '0;
          end
        end
        LONG_HELD: begin
          if (fall) begin
            state <= IDLE;
            timer <= '0;
          end
        end
        WAIT2: begin
          if (rise) begin
            state <= PRESS2;
            timer <= '0;
          end else if (timer == DBL_LAST) begin
            short_o <= 1'b1;
            state   <= IDLE;
            timer   <= '0;
          end
        end
        PRESS2: begin
          // A held second press still counts as a double; no long pulse follows.
          if (fall) begin
            double_o <= 1'b1;
            state    <= IDLE;
            timer    <= '0;
          end else if (timer == LONG_LAST) begin
            double_o <= 1'b1;
            state    <= LONG_HELD;
            timer    <= '0;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Scoreboard bench: each gesture pushes its expected pulse kind and cycle;
// a negedge monitor pops and compares whenever a pulse appears.
module tb_btn_press_classifier;

  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int DBL  = 10;

  localparam int K_SHORT  = 1;
  localparam int K_LONG   = 2;
  localparam int K_DOUBLE = 3;

  logic clk;
  logic rst_n;
  logic btn_in;
  logic pressed_o, short_o, long_o, double_o;

  btn_press_classifier #(
    .DB_CYCLES  (DB),
    .LONG_CYCLES(LONG),
    .DBL_CYCLES (DBL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_in   (btn_in),
    .pressed_o(pressed_o),
    .short_o  (short_o),
    .long_o   (long_o),
    .double_o (double_o)
  );

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   t0;
  int   mon_k;
  exp_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic v, input int n);
    btn_in = v;
    step(n);
  endtask

  task automatic expect_pulse(input int k, input int c);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Pulse monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (short_o || long_o || double_o)) begin
      mon_k = short_o ? K_SHORT : (long_o ? K_LONG : K_DOUBLE);
      chk("onehot", int'(short_o) + int'(long_o) + int'(double_o), 1);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", mon_k, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_kind", mon_k, mon_e.kind);
        chk("pulse_cyc", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    btn_in = 1'b0;
    step(3);
    chk("rst_pressed", pressed_o, 0);
    chk("rst_short", short_o, 0);
    chk("rst_long", long_o, 0);
    chk("rst_double", double_o, 0);
    rst_n = 1'b1;
    step(5);

    // Debounce latency, then the same press held 25 cycles becomes a long press.
    t0 = cyc;
    expect_pulse(K_LONG, t0 + 6 + LONG);
    btn_in = 1'b1;
    step(5);
    chk("db_lat_early", pressed_o, 0);
    step(1);
    chk("db_lat", pressed_o, 1);
    step(19);
    drive(1'b0, 30);
    chk("long_released", pressed_o, 0);

    // Glitches of 1 and 3 cycles never reach the debounced level.
    drive(1'b1, 1);
    drive(1'b0, 10);
    drive(1'b1, 3);
    btn_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("glitch", pressed_o, 0);
      step(1);
    end

    // Short press: 8 debounced cycles.
    t0 = cyc;
    expect_pulse(K_SHORT, t0 + 14 + DBL);
    drive(1'b1, 8);
    drive(1'b0, 30);

    // Release coincides with long expiry: release wins.
    t0 = cyc;
    expect_pulse(K_SHORT, t0 + 25 + DBL);
    drive(1'b1, 19);
    drive(1'b0, 40);

    // Held one cycle longer: long fires, nothing on release.
    t0 = cyc;
    expect_pulse(K_LONG, t0 + 26);
    drive(1'b1, 20);
    drive(1'b0, 30);

    // Double: press 5, gap 6, press 5.
    t0 = cyc;
    expect_pulse(K_DOUBLE, t0 + 23);
    drive(1'b1, 5);
    drive(1'b0, 6);
    drive(1'b1, 5);
    drive(1'b0, 30);

    // Second rise lands on the gap expiry cycle: double, no short.
    t0 = cyc;
    expect_pulse(K_DOUBLE, t0 + 26);
    drive(1'b1, 5);
    drive(1'b0, 9);
    drive(1'b1, 5);
    drive(1'b0, 30);

    // Gap of 11: first press times out as short, second is a fresh short.
    t0 = cyc;
    expect_pulse(K_SHORT, t0 + 21);
    expect_pulse(K_SHORT, t0 + 37);
    drive(1'b1, 5);
    drive(1'b0, 11);
    drive(1'b1, 5);
    drive(1'b0, 40);

    // Held second press: double at the long expiry, never long.
    t0 = cyc;
    expect_pulse(K_DOUBLE, t0 + 17 + LONG);
    drive(1'b1, 5);
    drive(1'b0, 6);
    drive(1'b1, 25);
    drive(1'b0, 30);

    // Reset during PRESS1 with the button held through release.
    btn_in = 1'b1;
    step(15);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_p1", {pressed_o, short_o, long_o, double_o}, 0);
    step(3);
    rst_n = 1'b1;
    t0 = cyc;
    expect_pulse(K_LONG, t0 + 6 + LONG);
    step(5);
    chk("rst_rel_early", pressed_o, 0);
    step(1);
    chk("rst_rel_pressed", pressed_o, 1);
    step(25);
    drive(1'b0, 30);

    // Reset during WAIT2: the pending short is discarded.
    drive(1'b1, 5);
    btn_in = 1'b0;
    step(14);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_w2", {pressed_o, short_o, long_o, double_o}, 0);
    step(3);
    rst_n = 1'b1;
    step(30);
    chk("rst_w2_pressed", pressed_o, 0);

    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
